// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - chip codes and per-chip bus timing constants for the bus arbiter
//
// Purpose: shared chip model codes, raster-line lengths, sprite p-access
// base cycles, badline window bounds and the BA warning length.
// Ports: none (package).

package bus_arbiter_pkg;

  typedef logic [1:0] chip_t;

  // Chip model codes; every 6569 variant has bit 0 set.
  localparam chip_t CHIP6567R8   = 2'd0;
  localparam chip_t CHIP6569R3   = 2'd1;
  localparam chip_t CHIP6567R56A = 2'd2;
  localparam chip_t CHIP6569R1   = 2'd3;

  localparam logic [6:0] BADLINE_BA_FIRST  = 7'd12;
  localparam logic [6:0] BADLINE_DMA_FIRST = 7'd15;
  localparam logic [6:0] BADLINE_LAST      = 7'd54;

  // Number of low-BA cycles the CPU is granted before AEC may be stolen in phi2.
  localparam logic [1:0] BA_WARN = 2'd3;

  // Cycles per raster line.
  function automatic logic [6:0] cycles_per_line(input chip_t chip);
    if (chip[0])
      return 7'd63;
    else if (chip == CHIP6567R56A)
      return 7'd64;
    else
      return 7'd65;
  endfunction

  // Cycle of sprite 0's p-access; sprite n follows at +2n.
  function automatic logic [6:0] sprite_base_cycle(input chip_t chip);
    return chip[0] ? 7'd57 : 7'd58;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - sequencer inputs and CPU-side bus control outputs of the bus arbiter
//
// Purpose: bundles the sequencer timing inputs with the BA/AEC outputs.
// Ports (master = arbiter side):
//   chip, clk_phi, phi_phase_start_1, cycle_num, badline, sprite_dma : into arbiter
//   ba, aec, ba_age                                                  : out of arbiter

interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  chip_t       chip;
  logic        clk_phi;
  logic        phi_phase_start_1;
  logic [6:0]  cycle_num;
  logic        badline;
  logic [7:0]  sprite_dma;
  logic        ba;
  logic        aec;
  logic [1:0]  ba_age;

  modport master (
    input  chip, clk_phi, phi_phase_start_1, cycle_num, badline, sprite_dma,
    output ba, aec, ba_age
  );

  modport slave (
    output chip, clk_phi, phi_phase_start_1, cycle_num, badline, sprite_dma,
    input  ba, aec, ba_age
  );

endinterface

// File: rtl/bus_arbiter_dma_window.sv
// rtl/bus_arbiter_dma_window.sv - combinational decoder of BA request and DMA cycles
//
// Purpose: decides from the current cycle whether BA must be low (ba_req)
// and whether this cycle's phi2 belongs to the video chip (dma_now).
// Ports:
//   chip       in  chip model code
//   cycle_num  in  current cycle in the raster line
//   badline    in  badline condition
//   sprite_dma in  per-sprite DMA enable
//   ba_req     out any active BA window covers cycle_num
//   dma_now    out any active DMA set contains cycle_num

module bus_arbiter_dma_window
  import bus_arbiter_pkg::*;
(
  input  chip_t      chip,
  input  logic [6:0] cycle_num,
  input  logic       badline,
  input  logic [7:0] sprite_dma,
  output logic       ba_req,
  output logic       dma_now
);

  logic [7:0] len;
  logic [7:0] p;
  logic [7:0] d;

  always_comb begin
    len     = {1'b0, cycles_per_line(chip)};
    p       = 8'd0;
    d       = 8'd0;
    ba_req  = badline && (cycle_num >= BADLINE_BA_FIRST)  && (cycle_num <= BADLINE_LAST);
    dma_now = badline && (cycle_num >= BADLINE_DMA_FIRST) && (cycle_num <= BADLINE_LAST);
    for (int n = 0; n < 8; n++) begin
      p = {1'b0, sprite_base_cycle(chip)} + 8'(2 * n);
      if (p >= len) p = p - len;
      // d is the offset of cycle_num from the window start P-3, modulo L,
      // so a window that wraps past L-1 is handled like any other.
      d = {1'b0, cycle_num} + len + 8'd3 - p;
      if (d >= len) d = d - len;
      if (d >= len) d = d - len;
      if (sprite_dma[n]) begin
        if (d < 8'd5) ba_req = 1'b1;
        if (d == 8'd3 || d == 8'd4) dma_now = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - BA/AEC bus sharing between the CPU and video DMA
//
// Purpose: registers BA, AEC and the BA age counter on the phi phase ticks.
// Ports:
//   clk_dot4x in  dot clock x4
//   rst       in  asynchronous active-high reset
//   bus       master modport of bus_arbiter_if (timing inputs, ba/aec/ba_age)

module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic          clk_dot4x,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  logic       ba_req;
  logic       dma_now;
  logic       cycle_tick;
  logic       phase2_tick;
  logic       ba_q;
  logic       aec_q;
  logic [1:0] age_q;

  bus_arbiter_dma_window u_window (
    .chip       (bus.chip),
    .cycle_num  (bus.cycle_num),
    .badline    (bus.badline),
    .sprite_dma (bus.sprite_dma),
    .ba_req     (ba_req),
    .dma_now    (dma_now)
  );

  assign cycle_tick  = bus.phi_phase_start_1 && !bus.clk_phi;
  assign phase2_tick = bus.phi_phase_start_1 &&  bus.clk_phi;

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      ba_q  <= 1'b1;
      aec_q <= 1'b0;
      age_q <= 2'd0;
    end else if (cycle_tick) begin
      ba_q  <= !ba_req;
      age_q <= ba_req ? ((age_q == BA_WARN) ? BA_WARN : age_q + 2'd1) : 2'd0;
      // phi1 always belongs to the video chip.
      aec_q <= 1'b0;
    end else if (phase2_tick) begin
      // The CPU keeps phi2 until it has seen BA low for the full warning.
      aec_q <= !(dma_now && age_q == BA_WARN);
    end
  end

  assign bus.ba     = ba_q;
  assign bus.aec    = aec_q;
  assign bus.ba_age = age_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Schedules sharing of the system bus between the CPU and the video chip's DMA (c-accesses on badlines, sprite p/s-accesses). It sits beside the cycle sequencer and consumes the same `chip`, `cycle_num`, `badline` and `sprite_dma` signals. From them it drives the BA (bus available) and AEC (address enable control) outputs to the CPU side. BA falls three cycles ahead of every phi2 DMA stretch, and AEC is only stolen once that warning has elapsed.

## Interface
- No parameters; per-chip timing constants live in the shared package.
- `clk_dot4x` in 1: dot clock x4, the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `chip` in 2: chip model code (`CHIP6567R56A`, `CHIP6567R8`, 6569 variants with `chip[0]`=1).
- `clk_phi` in 1: current phi level.
- `phi_phase_start_1` in 1: one-tick strobe at the start of each phi half.
- `cycle_num` in 7: current 0-based cycle within the raster line.
- `badline` in 1: badline condition, live.
- `sprite_dma` in 8: per-sprite DMA enable, live.
- `ba` out 1: bus available, active-high; low requests the CPU halt.
- `aec` out 1: 0 means the video chip drives the bus.
- `ba_age` out 2: cycles since BA fell, saturating at 3. Used for debug and addressgen.

## Operation
- Cycle tick is `phi_phase_start_1 && !clk_phi`. Phase-2 tick is `phi_phase_start_1 && clk_phi`. No state changes on other edges.
- Window decoder, combinational, evaluated on `cycle_num`:
  - Lines have 63 cycles (6569), 64 cycles (R56A) and 65 cycles (R8).
  - Badline BA window is cycles 12..54. The c-access (DMA) set is cycles 15..54.
  - Sprite n's p-access cycle is P(n) = (B + 2n) mod L, with B = 57 (6569) or 58 (6567 both).
  - Sprite n's BA window is P(n)-3 .. P(n)+1 mod L. Its DMA set is P(n) and P(n)+1 mod L.
  - A sprite window is active only while `sprite_dma[n]`=1.
  - `ba_req` is the OR of all active windows. `dma_now` is the OR of all active DMA sets.
- On a cycle tick:
  - `ba <= !ba_req`.
  - If `ba_req`: `ba_age <= min(ba_age+1, 3)`, where the first low cycle yields 1. Otherwise `ba_age <= 0`.
  - `aec <= 0`, because phi1 always belongs to the video chip.
- On a phase-2 tick: `aec <= !(dma_now && ba_age == 3)`.
- Late request: BA falls immediately. AEC stays high, so the CPU finishes, until the third low cycle's phase 2.
- Request withdrawn (badline drops or `sprite_dma` clears): BA returns high on the next cycle tick, `ba_age` clears, and AEC is released at the next phase 2.
- Overlapping windows merge; BA stays low with no high glitch between them.
- Window arithmetic wraps modulo L. A window crossing cycle L-1 → 0 is contiguous.
- `chip` is static outside reset. A change mid-line gives undefined windows for that line only.

## Timing
- Reset values: `ba`=1, `aec`=0, `ba_age`=0. Reset is asynchronous, so reset mid-DMA releases BA immediately.
- BA latency is one cycle tick after `cycle_num` enters a window. All outputs are registered.
- AEC changes only on the two phase ticks. It is never low during phi2 unless `ba_age`==3 at that tick.

## Structure
- Shared package `common.vh` gains:
  - `CYCLES_PER_LINE` per chip.
  - `SPRITE_BASE_CYCLE` per chip.
  - `BADLINE_BA_FIRST`=12, `BADLINE_DMA_FIRST`=15, `BADLINE_LAST`=54.
  - `BA_WARN`=3.
  - The existing chip codes are reused.
- One sub-module, `dma_window`: purely combinational decoder from (`chip`, `cycle_num`, `badline`, `sprite_dma`) to (`ba_req`, `dma_now`). The top module holds the tick decode, `ba_age` counter and output registers.

## Test plan
- 6569, `badline` high all line, no sprites:
  - `ba` falls at the cycle-12 tick and `ba_age` reaches 3 at cycle 14.
  - `aec`=0 in phi2 for cycles 15..54.
  - `ba` rises at the cycle-55 tick.
- Late badline, asserted at cycle 20:
  - `ba` falls at the cycle-20 tick.
  - `aec` stays 1 in phi2 of cycles 20 and 21, then goes low from cycle 22 phi2 (`ba_age`=3).
- 6569, only `sprite_dma[0]`=1: `ba` is low for cycles 54..58, and `aec`=0 in phi2 of cycles 57 and 58 only.
- 6567R8, `sprite_dma[7]`=1 (P=72 mod 65 = 7): `ba` is low for cycles 4..8, and `aec` is low in phi2 of cycles 7 and 8.
- 6569, `sprite_dma`=8'hFF with `badline`: `ba` stays continuously low from cycle 12 through the wrap to cycle 9 of the next line, with no high glitch.
- `rst` pulsed in cycle 30 of a badline (DMA active): `ba`=1, `aec`=0, `ba_age`=0 immediately. After release, `ba` falls at the next cycle tick and `aec` is held high in phi2 until 3 cycles have elapsed.
